// File: rtl/kms_event_queue.sv
// Keyboard/mouse event buffer fed by the HPS toggle-level KMS channel:
// tagged FWFT key FIFO plus saturating mouse delta accumulators with snapshot.
module kms_event_queue #(
  parameter int unsigned KBD_DEPTH = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       kms_level,
  input  logic [1:0] kms_type,
  input  logic [7:0] kms_data,
  input  logic [2:0] mouse_buttons_in,
  output logic       kbd_valid,
  output logic [7:0] kbd_data,
  output logic       kbd_osd,
  input  logic       kbd_ack,
  output logic       kbd_ovf,
  input  logic       mouse_take,
  output logic [7:0] mouse_dx,
  output logic [7:0] mouse_dy,
  output logic [2:0] mouse_btn,
  output logic       mouse_pending
);

  localparam int unsigned AW = $clog2(KBD_DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(KBD_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

  logic          lvl_q;
  logic          armed;
  logic          evt;
  logic          key_evt;
  logic          push;
  logic          pop;
  logic          full;
  logic [8:0]    mem [KBD_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    acc_x;
  logic [7:0]    acc_y;
  logic [7:0]    base_x;
  logic [7:0]    base_y;
  logic          x_evt;
  logic          y_evt;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] d);
    logic [8:0] s;
    s = {a[7], a} + {d[7], d};
    if (s[8] != s[7]) sat_add = s[8] ? 8'h80 : 8'h7f;
    else              sat_add = s[7:0];
  endfunction

  // First edge after reset only samples the level; the source state is unknown.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lvl_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      lvl_q <= kms_level;
      armed <= 1'b1;
    end
  end

  assign evt     = armed & (kms_level ^ lvl_q);
  assign key_evt = evt & kms_type[1];
  assign x_evt   = evt & (kms_type == 2'd0);
  assign y_evt   = evt & (kms_type == 2'd1);

  assign kbd_valid = (count != '0);
  assign full      = (count == CNT_FULL);
  assign pop       = kbd_valid & kbd_ack;
  assign push      = key_evt & (~full | pop);
  assign {kbd_osd, kbd_data} = kbd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= {kms_type[0], kms_data};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      kbd_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
      if (key_evt && !push)  kbd_ovf <= 1'b1;
    end
  end

  // A take clears the accumulators first, so a same-cycle delta starts from zero.
  assign base_x = mouse_take ? 8'h00 : acc_x;
  assign base_y = mouse_take ? 8'h00 : acc_y;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      acc_x     <= '0;
      acc_y     <= '0;
      mouse_dx  <= '0;
      mouse_dy  <= '0;
      mouse_btn <= '0;
    end else begin
      acc_x <= x_evt ? sat_add(base_x, kms_data) : base_x;
      acc_y <= y_evt ? sat_add(base_y, kms_data) : base_y;
      if (mouse_take) begin
        mouse_dx  <= acc_x;
        mouse_dy  <= acc_y;
        mouse_btn <= mouse_buttons_in;
      end
    end
  end

  assign mouse_pending = (acc_x != '0) | (acc_y != '0);

endmodule
